// File: rtl/hbus_pkg.sv
// Shared definitions for the system-bus decoder: FSM encoding, fault codes
// and the address-window compare used by the decoder.
package hbus_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_ERR1 = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_UNMAPPED = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef struct packed {
    logic [1:0] code;
    logic [2:0] slave;
  } fault_t;

  // Addresses are zero-extended to 32 bits so one function serves every ADDR_W.
  function automatic logic region_match(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/hbus_wdt.sv
// Data-phase watchdog: counts wait states of the selected slave and flags
// the cycle in which the TIMEOUT-th wait state is being spent.
module hbus_wdt
  import hbus_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic hclk,
  input  logic hreset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);
  localparam logic [W-1:0] LAST  = (TIMEOUT > 0) ? W'(TIMEOUT - 1) : '0;

  logic [W-1:0] r_wcnt;

  // Saturating: once at LIMIT the counter holds instead of wrapping.
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      r_wcnt <= '0;
    end else if (i_clr) begin
      r_wcnt <= '0;
    end else if (i_en && (r_wcnt != LIMIT)) begin
      r_wcnt <= r_wcnt + 1'b1;
    end
  end

  assign o_expired = (TIMEOUT != 0) && i_en && (r_wcnt == LAST);

endmodule

// File: rtl/hbus_decoder.sv
// Address decoder, response mux, default ERROR slave and hready watchdog
// for the shrunk-AHB system bus.
//   state | meaning
//   IDLE  | no data phase pending, bus ready
//   DATA  | data phase owned by slave r_dsel
//   ERR1  | first ERROR cycle (hready low), fault logged on entry
//   ERR2  | second ERROR cycle (hready high), may accept next address
module hbus_decoder
  import hbus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8,
  parameter int NSLV = 4,
  parameter logic [NSLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NSLV*ADDR_W-1:0] SLV_MASK = '0,
  parameter int TIMEOUT = 255
) (
  input  logic                   hclk,
  input  logic                   hreset_n,
  input  logic [ADDR_W-1:0]      m_haddr,
  input  logic                   m_htrans,
  input  logic                   m_hwrite,
  output logic [DATA_W-1:0]      m_hrdata,
  output logic                   m_hready,
  output logic                   m_hresp,
  output logic [NSLV-1:0]        s_hsel,
  output logic                   s_hready_bus,
  input  logic [NSLV*DATA_W-1:0] s_hrdata,
  input  logic [NSLV-1:0]        s_hready,
  input  logic [NSLV-1:0]        s_hresp,
  output logic                   err_valid,
  output logic [1:0]             err_code,
  output logic [2:0]             err_slave,
  output logic [ADDR_W-1:0]      err_addr,
  input  logic                   err_clr
);

  logic [1:0]        r_state;
  logic [2:0]        r_dsel;
  logic [ADDR_W-1:0] r_daddr;
  logic              r_err_valid;
  fault_t            r_fault;
  logic [ADDR_W-1:0] r_err_addr;

  logic              w_hit;
  logic [2:0]        w_hit_idx;
  logic [DATA_W-1:0] w_slv_rdata;
  logic              w_slv_ready;
  logic              w_slv_resp;
  logic              w_accept;
  logic              w_expired;
  logic [1:0]        w_state_nxt;
  logic              w_unused;

  // Scan upward so the lowest matching index claims overlapping windows.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    s_hsel    = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (!w_hit && region_match(32'(m_haddr), 32'(SLV_BASE[i*ADDR_W +: ADDR_W]),
                                 32'(SLV_MASK[i*ADDR_W +: ADDR_W]))) begin
        w_hit     = 1'b1;
        w_hit_idx = 3'(i);
        s_hsel[i] = m_htrans;
      end
    end
  end

  always_comb begin
    w_slv_rdata = '0;
    w_slv_ready = 1'b0;
    w_slv_resp  = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (r_dsel == 3'(i)) begin
        w_slv_rdata = s_hrdata[i*DATA_W +: DATA_W];
        w_slv_ready = s_hready[i];
        w_slv_resp  = s_hresp[i];
      end
    end
  end

  always_comb begin
    m_hready = 1'b1;
    m_hresp  = 1'b0;
    m_hrdata = '0;
    case (r_state)
      ST_DATA: begin
        m_hready = w_slv_ready;
        m_hresp  = w_slv_resp;
        m_hrdata = w_slv_rdata;
      end
      ST_ERR1: begin
        m_hready = 1'b0;
        m_hresp  = 1'b1;
      end
      ST_ERR2: m_hresp = 1'b1;
      default: ;
    endcase
  end

  assign s_hready_bus = m_hready;
  assign w_accept     = m_htrans & m_hready;
  assign w_unused     = m_hwrite;

  hbus_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
    .hclk      (hclk),
    .hreset_n  (hreset_n),
    .i_clr     (w_accept & w_hit),
    .i_en      ((r_state == ST_DATA) & ~w_slv_ready),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_ERR1) begin
      w_state_nxt = ST_ERR2;
    end else if (m_hready) begin
      w_state_nxt = w_accept ? (w_hit ? ST_DATA : ST_ERR1) : ST_IDLE;
    end else if (w_expired) begin
      w_state_nxt = ST_ERR1;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      r_state     <= ST_IDLE;
      r_dsel      <= '0;
      r_daddr     <= '0;
      r_err_valid <= 1'b0;
      r_fault     <= '{code: ERR_NONE, slave: 3'd0};
      r_err_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_dsel  <= w_hit_idx;
        r_daddr <= m_haddr;
      end
      // A fault arriving with err_clr still wins.
      if (w_accept && !w_hit) begin
        r_err_valid <= 1'b1;
        r_fault     <= '{code: ERR_UNMAPPED, slave: 3'd0};
        r_err_addr  <= m_haddr;
      end else if (w_expired) begin
        r_err_valid <= 1'b1;
        r_fault     <= '{code: ERR_TIMEOUT, slave: r_dsel};
        r_err_addr  <= r_daddr;
      end else if (err_clr) begin
        r_err_valid <= 1'b0;
      end
    end
  end

  assign err_valid = r_err_valid;
  assign err_code  = r_fault.code;
  assign err_slave = r_fault.slave;
  assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_hbus_decoder.sv
// Scoreboard bench for hbus_decoder: two slaves with overlapping windows,
// TIMEOUT=4, directed transfers with hand-computed responses.
module tb_hbus_decoder;

  logic        hclk = 1'b0;
  logic        hreset_n;
  logic [23:0] m_haddr;
  logic        m_htrans;
  logic        m_hwrite;
  logic [7:0]  m_hrdata;
  logic        m_hready;
  logic        m_hresp;
  logic [1:0]  s_hsel;
  logic        s_hready_bus;
  logic [15:0] s_hrdata;
  logic [1:0]  s_hready;
  logic [1:0]  s_hresp;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [2:0]  err_slave;
  logic [23:0] err_addr;
  logic        err_clr;

  hbus_decoder #(
    .ADDR_W(24), .DATA_W(8), .NSLV(2),
    .SLV_BASE({24'hC00000, 24'hC00500}),
    .SLV_MASK({24'hFF0000, 24'hFFFF00}),
    .TIMEOUT(4)
  ) dut (
    .hclk(hclk), .hreset_n(hreset_n), .m_haddr(m_haddr), .m_htrans(m_htrans),
    .m_hwrite(m_hwrite), .m_hrdata(m_hrdata), .m_hready(m_hready), .m_hresp(m_hresp),
    .s_hsel(s_hsel), .s_hready_bus(s_hready_bus), .s_hrdata(s_hrdata),
    .s_hready(s_hready), .s_hresp(s_hresp), .err_valid(err_valid),
    .err_code(err_code), .err_slave(err_slave), .err_addr(err_addr), .err_clr(err_clr)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic [7:0] rdata;
    logic       resp;
    int         waits;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: tracks the data phase from bus signals only and pops on completion.
  initial begin : monitor
    bit   pending = 0;
    int   waits = 0;
    exp_t e;
    forever begin
      @(negedge hclk);
      if (!hreset_n) begin
        pending = 0;
        waits = 0;
      end else begin
        if (pending) begin
          if (!m_hready) begin
            waits++;
          end else begin
            if (exp_q.size() == 0) begin
              check("unexpected_completion", 32'(m_hresp), 32'hDEAD);
            end else begin
              e = exp_q.pop_front();
              check({e.name, "_resp"}, 32'(m_hresp), 32'(e.resp));
              check({e.name, "_waits"}, 32'(waits), 32'(e.waits));
              if (!e.resp) check({e.name, "_rdata"}, 32'(m_hrdata), 32'(e.rdata));
            end
            pending = 0;
            waits = 0;
          end
        end
        if (m_htrans && m_hready) pending = 1;
      end
    end
  end

  // Drives one address phase; returns #1 after the accepting edge.
  task automatic issue(input logic [23:0] addr, input logic [1:0] exp_hsel, input bit push,
                       input logic [7:0] rdata, input logic resp, input int waits,
                       input string name);
    exp_t e;
    int   n;
    m_haddr  = addr;
    m_htrans = 1'b1;
    if (push) begin
      e.rdata = rdata; e.resp = resp; e.waits = waits; e.name = name;
      exp_q.push_back(e);
    end
    @(negedge hclk);
    check({name, "_hsel"}, 32'(s_hsel), 32'(exp_hsel));
    n = 0;
    while (!m_hready && n < 50) begin
      @(negedge hclk);
      n++;
    end
    if (n >= 50) check({name, "_accept_timeout"}, 32'(m_hready), 32'h1);
    @(posedge hclk);
    #1;
    m_htrans = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask

  initial begin
    hreset_n = 1'b0;
    m_haddr  = '0;
    m_htrans = 1'b0;
    m_hwrite = 1'b0;
    s_hrdata = {8'hB1, 8'hA0};
    s_hready = 2'b11;
    s_hresp  = 2'b00;
    err_clr  = 1'b0;
    idle(3);
    check("rst_hready", 32'(m_hready), 32'h1);
    check("rst_hready_bus", 32'(s_hready_bus), 32'h1);
    check("rst_hresp", 32'(m_hresp), 32'h0);
    check("rst_hrdata", 32'(m_hrdata), 32'h0);
    check("rst_hsel", 32'(s_hsel), 32'h0);
    check("rst_err", {err_valid, err_code, err_slave}, 32'h0);
    check("rst_err_addr", 32'(err_addr), 32'h0);
    hreset_n = 1'b1;
    idle(1);

    // Address in both windows: slave0 wins.
    issue(24'hC00512, 2'b01, 1, 8'hA0, 1'b0, 0, "rd_s0");
    idle(1);
    issue(24'hC01234, 2'b10, 1, 8'hB1, 1'b0, 0, "rd_s1");
    idle(1);

    s_hresp = 2'b01;
    issue(24'hC00512, 2'b01, 1, 8'hA0, 1'b1, 0, "s0_err_pass");
    idle(1);
    s_hresp = 2'b00;
    check("no_fault_logged", 32'(err_valid), 32'h0);

    issue(24'hFFFFFF, 2'b00, 1, 8'h00, 1'b1, 1, "unmapped");
    idle(2);
    check("unm_valid", 32'(err_valid), 32'h1);
    check("unm_code", 32'(err_code), 32'h1);
    check("unm_slave", 32'(err_slave), 32'h0);
    check("unm_addr", 32'(err_addr), 32'hFFFFFF);

    // Three wait states, one short of the limit, completes normally.
    s_hready = 2'b01;
    issue(24'hC01234, 2'b10, 1, 8'hB1, 1'b0, 3, "wait3");
    idle(3);
    s_hready = 2'b11;
    idle(2);

    // Timeout: DATA x4 + ERR1 low, late ready during ERR1 ignored.
    s_hready = 2'b01;
    issue(24'hC01234, 2'b10, 1, 8'h00, 1'b1, 5, "timeout");
    idle(4);
    s_hready = 2'b11;
    idle(1);
    s_hready = 2'b01;
    check("to_valid", 32'(err_valid), 32'h1);
    check("to_code", 32'(err_code), 32'h2);
    check("to_slave", 32'(err_slave), 32'h1);
    check("to_addr", 32'(err_addr), 32'hC01234);
    idle(1);
    s_hready = 2'b11;
    idle(2);

    // Back-to-back: slave0 -> unmapped -> slave1 without bubbles.
    issue(24'hC00500, 2'b01, 1, 8'hA0, 1'b0, 0, "b2b_s0");
    issue(24'h123456, 2'b00, 1, 8'h00, 1'b1, 1, "b2b_unm");
    issue(24'hC0FFFF, 2'b10, 1, 8'hB1, 1'b0, 0, "b2b_s1");
    idle(2);
    check("b2b_code", 32'(err_code), 32'h1);
    check("b2b_addr", 32'(err_addr), 32'h123456);

    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("clr_alone_1", 32'(err_valid), 32'h0);
    err_clr = 1'b1;
    issue(24'hABCDEF, 2'b00, 1, 8'h00, 1'b1, 1, "fault_vs_clr");
    err_clr = 1'b0;
    check("fault_wins", 32'(err_valid), 32'h1);
    idle(3);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("clr_alone_2", 32'(err_valid), 32'h0);

    // Reset in DATA drops the transfer; no completion expected.
    s_hready = 2'b01;
    issue(24'hC01234, 2'b10, 0, 8'h00, 1'b0, 0, "rst_mid");
    idle(1);
    hreset_n = 1'b0;
    idle(1);
    check("rst_mid_hready", 32'(m_hready), 32'h1);
    check("rst_mid_hresp", 32'(m_hresp), 32'h0);
    hreset_n = 1'b1;
    s_hready = 2'b11;
    idle(3);
    check("rst_mid_no_err", 32'(err_valid), 32'h0);

    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge hclk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
